scan_pattern_driver: RTL and testbench
======================================

SCAN_PATTERN_DRIVER -- requirements
Module: scan_pattern_driver

Interface
REQ-001 Parameter: CHAIN_LEN, default 16, flops per scan chain (all four chains equal length, CHAIN_LEN >= 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run a pattern set; ignored while busy=1.
REQ-006 num_pat  input  8  pattern count, latched on accepted start.
REQ-007 exp_sig  input  16  expected final signature, compared at completion.
REQ-008 pat_data  input  4  one shift slice: bit i feeds chain i+1.
REQ-009 pat_valid / pat_ready  input / output  1 / 1  slice handshake; transfer when both are 1 on a rising edge.
REQ-010 TEST_SI1..TEST_SI4  output  1 each  scan-in to the core's chains 1..4.
REQ-011 TEST_SE  output  1  scan enable to the core.
REQ-012 TEST_SO1..TEST_SO4  input  1 each  scan-out from the core's chains 1..4.
REQ-013 busy  output  1  high from the cycle after an accepted start through the DONE state.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 signature  output  16  MISR contents, held stable after done until the next start.
REQ-016 pass / error  output  1 / 1  valid from the done pulse until the next start.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, CAPTURE, FLUSH and DONE. All outputs SHALL be Moore outputs, decoded from registers, with no combinational input-to-output path.
REQ-018 IDLE + start with num_pat=0 -> DONE. IDLE + start with num_pat!=0 -> LOAD. On either transition, signature SHALL be seeded to 16'hFFFF, pat_cnt cleared to 0, and error cleared to 0.
REQ-019 LOAD: pat_ready=1 and TEST_SE=0. Slices SHALL be written into buffer A at index 0..CHAIN_LEN-1. The state SHALL advance to SHIFT on the edge that accepts slice CHAIN_LEN-1.
REQ-020 SHIFT: exactly CHAIN_LEN cycles with TEST_SE=1. In cycle k, TEST_SI{i+1} SHALL equal bit i of the active buffer slice k.
REQ-021 CAPTURE: exactly one cycle with TEST_SE=0 and TEST_SI*=0. On exit, pat_cnt SHALL increment.
- If pat_cnt reaches num_pat -> FLUSH.
- Else if the alternate buffer is full -> swap buffers, then SHIFT.
- Else -> set error=1, then DONE (underrun abort).
REQ-022 While in SHIFT or CAPTURE with pat_cnt+1 < num_pat, pat_ready SHALL be 1 until the alternate buffer holds CHAIN_LEN slices, and 0 otherwise. pat_ready SHALL be 0 in IDLE, FLUSH and DONE.
REQ-023 FLUSH: exactly CHAIN_LEN cycles with TEST_SE=1 and TEST_SI*=0, then -> DONE.
REQ-024 MISR update: so = {TEST_SO4, TEST_SO3, TEST_SO2, TEST_SO1}.
- sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {12'h000, so}.
- The update SHALL be applied on every SHIFT cycle with pat_cnt >= 1 and on every FLUSH cycle.
- TEST_SO SHALL be sampled on the same edge as the update.
REQ-025 DONE lasts one cycle: done=1, busy=1, pass=(signature==exp_sig)&&!error. The state then returns to IDLE.
REQ-026 A start asserted in any state other than IDLE SHALL have no effect.
REQ-027 Pattern k+1 SHALL shift in while response k shifts out, so each chain sees exactly one CAPTURE between consecutive shift windows.
REQ-028 Counter widths SHALL be $clog2(CHAIN_LEN) for the slice index and 8 bits for pat_cnt, and neither counter SHALL wrap within a legal run.

Reset
REQ-029 When rst is asserted, the block SHALL asynchronously force state=IDLE and the following outputs to 0: TEST_SE, TEST_SI1..4, pat_ready, busy, done, pass, error, signature (16'h0000). This SHALL hold in any state, including mid-SHIFT.
REQ-030 Pattern buffer contents are don't-care after reset and SHALL NOT affect any output before being rewritten.
REQ-031 On the first rising edge after rst deasserts, the block SHALL be in IDLE and SHALL accept start.

Verification
REQ-032 num_pat=0, start -> done the next cycle, signature=16'hFFFF, pass=1 iff exp_sig=16'hFFFF, TEST_SE never 1.
REQ-033 CHAIN_LEN=16, num_pat=3, pat_valid held at 1, core modelled as four 16-flop shift registers whose capture inverts every bit -> TEST_SE high for 16 cycles three times, then 16 flush cycles; signature equals a reference-model MISR; error=0.
REQ-034 num_pat=2 with pat_valid dropped after 10 slices of pattern 2 -> error=1 at the end of the first CAPTURE, done pulses, pass=0, and no second SHIFT window occurs.
REQ-035 rst asserted in the 5th SHIFT cycle -> all outputs are 0 before the next edge; a new start with num_pat=1 then completes normally.
REQ-036 start pulsed during SHIFT and CAPTURE -> ignored; pat_cnt and signature are unaffected; exactly one done pulse occurs per accepted start.
REQ-037 TEST_SO1..4 stuck at 0 versus fault-free, with the same 2 patterns -> the two signatures differ, and pass=1 only for the exp_sig matching the fault-free run.

Source files
------------

// File: rtl/scan_pattern_driver.sv
// Scan pattern driver: accepts 4-bit shift slices into a ping-pong buffer,
// drives four scan chains, overlaps load of pattern k+1 with unload of
// response k, and compacts scan-out data into a 16-bit MISR signature.
module scan_pattern_driver #(
    parameter int CHAIN_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  num_pat,
    input  logic [15:0] exp_sig,
    input  logic [3:0]  pat_data,
    input  logic        pat_valid,
    output logic        pat_ready,
    output logic        TEST_SI1,
    output logic        TEST_SI2,
    output logic        TEST_SI3,
    output logic        TEST_SI4,
    output logic        TEST_SE,
    input  logic        TEST_SO1,
    input  logic        TEST_SO2,
    input  logic        TEST_SO3,
    input  logic        TEST_SO4,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        pass,
    output logic        error
);

    localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]    buf_a [CHAIN_LEN];
    logic [3:0]    buf_b [CHAIN_LEN];
    logic          act_b;      // 1: buffer B feeds the chains
    logic          alt_full;   // the non-active buffer holds a full pattern
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] shift_idx;
    logic [7:0]    pat_cnt;
    logic [7:0]    num_q;
    logic [15:0]   exp_q;
    logic [15:0]   sig_q;
    logic          err_q;
    logic          res_q;      // result outputs valid until next start

    logic          xfer;
    logic          fill_last;
    logic          start_ok;
    logic          more_pat;
    logic          wr_b;
    logic [3:0]    so;
    logic [3:0]    slice;
    logic [15:0]   sig_nx;

    assign xfer      = pat_valid && pat_ready;
    assign fill_last = xfer && (fill_idx == LAST);
    assign start_ok  = (state == S_IDLE) && start;
    assign more_pat  = ({1'b0, pat_cnt} + 9'd1) < {1'b0, num_q};
    assign wr_b      = (state == S_LOAD) ? act_b : ~act_b;
    assign so        = {TEST_SO4, TEST_SO3, TEST_SO2, TEST_SO1};
    assign slice     = act_b ? buf_b[shift_idx] : buf_a[shift_idx];
    assign sig_nx    = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {12'h000, so};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and Moore output decode
    always_comb begin
        state_nx  = state;
        pat_ready = 1'b0;
        TEST_SE   = 1'b0;
        TEST_SI1  = 1'b0;
        TEST_SI2  = 1'b0;
        TEST_SI3  = 1'b0;
        TEST_SI4  = 1'b0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        signature = sig_q;
        error     = err_q;
        pass      = ((state == S_DONE) || res_q) && (sig_q == exp_q) && !err_q;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (num_pat == 8'd0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                pat_ready = 1'b1;
                if (fill_last) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                TEST_SE   = 1'b1;
                TEST_SI1  = slice[0];
                TEST_SI2  = slice[1];
                TEST_SI3  = slice[2];
                TEST_SI4  = slice[3];
                pat_ready = more_pat && !alt_full;
                if (shift_idx == LAST) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                pat_ready = more_pat && !alt_full;
                // A slice completing the alternate buffer on this edge still counts as full
                if (!more_pat)                   state_nx = S_FLUSH;
                else if (alt_full || fill_last)  state_nx = S_SHIFT;
                else                             state_nx = S_DONE;
            end
            S_FLUSH: begin
                TEST_SE = 1'b1;
                if (shift_idx == LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Run control: counters, buffer bookkeeping, error and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_b     <= 1'b0;
            alt_full  <= 1'b0;
            fill_idx  <= '0;
            shift_idx <= '0;
            pat_cnt   <= '0;
            num_q     <= '0;
            exp_q     <= '0;
            err_q     <= 1'b0;
            res_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                act_b     <= 1'b0;
                alt_full  <= 1'b0;
                fill_idx  <= '0;
                shift_idx <= '0;
                pat_cnt   <= '0;
                num_q     <= num_pat;
                exp_q     <= exp_sig;
                err_q     <= 1'b0;
                res_q     <= 1'b0;
            end
            if (state == S_DONE) res_q <= 1'b1;
            if (xfer) begin
                fill_idx <= fill_last ? '0 : fill_idx + 1'b1;
                if (fill_last && state != S_LOAD) alt_full <= 1'b1;
            end
            if (state == S_SHIFT || state == S_FLUSH)
                shift_idx <= (shift_idx == LAST) ? '0 : shift_idx + 1'b1;
            if (state == S_CAPTURE) begin
                pat_cnt <= pat_cnt + 8'd1;
                // Swap clears alt_full after any same-edge fill completion above
                if (more_pat && (alt_full || fill_last)) begin
                    act_b    <= ~act_b;
                    alt_full <= 1'b0;
                end else if (more_pat) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Ping-pong pattern buffers; contents only read after being written
    always_ff @(posedge clk) begin
        if (xfer) begin
            if (wr_b) buf_b[fill_idx] <= pat_data;
            else      buf_a[fill_idx] <= pat_data;
        end
    end

    // MISR: seeded on start, compacts responses during unload windows
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig_q <= '0;
        else if (start_ok)
            sig_q <= 16'hFFFF;
        else if ((state == S_SHIFT && pat_cnt != 8'd0) || state == S_FLUSH)
            sig_q <= sig_nx;
    end

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Bench for scan_pattern_driver: random patterns and valid gaps, a behavioural
// scan core, and a timeline/MISR reference computed from the pattern rules.
module tb_scan_pattern_driver;

    localparam int CL   = 16;
    localparam int MAXP = 8;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_pat;
    logic [15:0] exp_sig;
    logic [3:0]  pat_data;
    logic        pat_valid;
    logic        pat_ready;
    logic        TEST_SI1, TEST_SI2, TEST_SI3, TEST_SI4;
    logic        TEST_SE;
    logic        TEST_SO1, TEST_SO2, TEST_SO3, TEST_SO4;
    logic        busy, done, pass, error;
    logic [15:0] signature;

    int n_checks = 0;
    int n_errs   = 0;
    int sent     = 0;
    bit stuck    = 1'b0;

    logic [CL-1:0] ch [4];
    logic [3:0]    strm [MAXP*CL];
    bit            vmask [MAXC];

    always #5 clk = ~clk;

    scan_pattern_driver #(.CHAIN_LEN(CL)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pat(num_pat), .exp_sig(exp_sig),
        .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .TEST_SI1(TEST_SI1), .TEST_SI2(TEST_SI2), .TEST_SI3(TEST_SI3), .TEST_SI4(TEST_SI4),
        .TEST_SE(TEST_SE),
        .TEST_SO1(TEST_SO1), .TEST_SO2(TEST_SO2), .TEST_SO3(TEST_SO3), .TEST_SO4(TEST_SO4),
        .busy(busy), .done(done), .signature(signature), .pass(pass), .error(error)
    );

    // Core model: four shift chains, capture inverts every flop
    always @(posedge clk) begin
        if (TEST_SE) begin
            ch[0] <= {ch[0][CL-2:0], TEST_SI1};
            ch[1] <= {ch[1][CL-2:0], TEST_SI2};
            ch[2] <= {ch[2][CL-2:0], TEST_SI3};
            ch[3] <= {ch[3][CL-2:0], TEST_SI4};
        end else begin
            for (int i = 0; i < 4; i++) ch[i] <= ~ch[i];
        end
    end

    assign TEST_SO1 = stuck ? 1'b0 : ch[0][CL-1];
    assign TEST_SO2 = stuck ? 1'b0 : ch[1][CL-1];
    assign TEST_SO3 = stuck ? 1'b0 : ch[2][CL-1];
    assign TEST_SO4 = stuck ? 1'b0 : ch[3][CL-1];

    // Count accepted slices
    always @(posedge clk) if (pat_valid && pat_ready) sent <= sent + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_se"},   TEST_SE, 0);
        check({tag, "_si"},   {TEST_SI4, TEST_SI3, TEST_SI2, TEST_SI1}, 0);
        check({tag, "_rdy"},  pat_ready, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"},  error, 0);
        check({tag, "_sig"},  signature, 0);
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] v);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, v};
    endfunction

    task automatic fill_patterns();
        for (int i = 0; i < MAXP*CL; i++) strm[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_mask(input int pct, input int lo, input int hi);
        for (int c = 0; c < MAXC; c++)
            vmask[c] = (c >= lo) && (c <= hi) && ($urandom_range(0, 99) < pct);
        vmask[0] = 1'b0;
    endtask

    // One start..done run, checked cycle by cycle against a timeline model
    task automatic run(input int n, input logic [15:0] exp_in, input bit exp_auto,
                       input bit stuck_in, input int rst_k, input bit noise,
                       output logic [15:0] sig_obs);
        int L, done_c, last_win, cnt, base, idx, rst_at;
        bit err, flush, e_rdy, e_se, e_pass;
        logic [3:0] e_si, v;
        logic [15:0] s, e_exp;
        int S [MAXP];
        int C [MAXP];
        int F [MAXP];
        L = 0; err = 0; flush = 0; last_win = -1; rst_at = -1; sig_obs = '0; done_c = 1;
        for (int p = 0; p < MAXP; p++) begin S[p] = 0; C[p] = 0; F[p] = 0; end
        if (n > 0) begin
            cnt = 0;
            for (int c = 1; c < MAXC; c++)
                if (vmask[c]) begin
                    cnt++;
                    if (cnt == CL) begin L = c; break; end
                end
            last_win = n - 1;
            for (int p = 0; p < n; p++) begin
                S[p] = L + 1 + p*(CL+1);
                C[p] = S[p] + CL;
                F[p] = C[p];
                if (p + 1 < n) begin
                    cnt = 0;
                    for (int c = S[p]; c <= C[p]; c++)
                        if (vmask[c]) begin
                            cnt++;
                            if (cnt == CL) begin F[p] = c; break; end
                        end
                    if (cnt < CL) begin err = 1; last_win = p; break; end
                end
            end
            flush  = !err;
            done_c = err ? C[last_win] + 1 : C[n-1] + 1 + CL;
            if (rst_k >= 0) rst_at = S[0] + rst_k;
        end
        s = 16'hFFFF;
        for (int p = 1; p <= last_win; p++)
            for (int k = 0; k < CL; k++) begin
                v = stuck_in ? 4'h0 : ~strm[(p-1)*CL + k];
                s = misr(s, v);
            end
        if (flush)
            for (int k = 0; k < CL; k++) begin
                v = stuck_in ? 4'h0 : ~strm[(n-1)*CL + k];
                s = misr(s, v);
            end
        e_exp  = exp_auto ? s : exp_in;
        e_pass = (s == e_exp) && !err;
        stuck   = stuck_in;
        exp_sig = e_exp;
        base    = sent;
        for (int c = 0; c <= done_c + 1; c++) begin
            start     = (c == 0) || (noise && n > 0 && (c == S[0] + 3 || c == C[0]));
            num_pat   = (c == 0) ? 8'(n) : 8'($urandom_range(1, 255));
            pat_valid = vmask[c];
            idx       = sent - base;
            pat_data  = (idx < MAXP*CL) ? strm[idx] : 4'h0;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero("midrst");
                start = 1'b0;
                pat_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            e_rdy = 0; e_se = 0; e_si = 4'h0;
            if (n > 0 && c >= 1 && c <= L) e_rdy = 1;
            for (int p = 0; p <= last_win; p++) begin
                if (c >= S[p] && c < S[p] + CL) begin
                    e_se = 1;
                    e_si = strm[p*CL + c - S[p]];
                end
                if (p + 1 < n && c >= S[p] && c <= C[p]) e_rdy = (c <= F[p]);
            end
            if (flush && c > C[n-1] && c <= C[n-1] + CL) e_se = 1;
            check("busy", busy, (c >= 1 && c <= done_c));
            check("done", done, (c == done_c));
            check("se", TEST_SE, e_se);
            check("si", {TEST_SI4, TEST_SI3, TEST_SI2, TEST_SI1}, e_si);
            check("rdy", pat_ready, e_rdy);
            if (c >= done_c) begin
                check("sig", signature, s);
                check("err", error, err);
                check("pass", pass, e_pass);
            end
            if (c == done_c) sig_obs = signature;
            @(negedge clk);
        end
        start = 1'b0;
        pat_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] sig_ff, sig_st, dummy;
        rst = 1'b1; start = 1'b0; num_pat = '0; exp_sig = '0; pat_data = '0; pat_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-pattern runs
        set_mask(0, 1, 0);
        run(0, 16'hFFFF, 1'b0, 1'b0, -1, 1'b0, dummy);
        run(0, 16'h1234, 1'b0, 1'b0, -1, 1'b0, dummy);

        // Three patterns, continuous valid
        fill_patterns();
        set_mask(100, 1, MAXC-1);
        run(3, 16'h0000, 1'b1, 1'b0, -1, 1'b0, dummy);

        // Underrun: valid stops after 10 slices of the second pattern
        fill_patterns();
        set_mask(100, 1, 26);
        run(2, 16'h0000, 1'b1, 1'b0, -1, 1'b0, dummy);

        // Reset in the 5th shift cycle, then a normal single-pattern run
        fill_patterns();
        set_mask(100, 1, MAXC-1);
        run(2, 16'h0000, 1'b1, 1'b0, 4, 1'b0, dummy);
        run(1, 16'h0000, 1'b1, 1'b0, -1, 1'b0, dummy);

        // Start pulses during SHIFT and CAPTURE are ignored
        fill_patterns();
        run(3, 16'h0000, 1'b1, 1'b0, -1, 1'b1, dummy);

        // Stuck-at-0 scan-out versus fault-free, same patterns
        fill_patterns();
        run(2, 16'h0000, 1'b1, 1'b0, -1, 1'b0, sig_ff);
        run(2, sig_ff, 1'b0, 1'b1, -1, 1'b0, sig_st);
        check("sig_differ", (sig_ff != sig_st), 1);
        stuck = 1'b0;

        // Random runs with random valid gaps
        for (int r = 0; r < 12; r++) begin
            int n, pct;
            n   = $urandom_range(1, 6);
            pct = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 95 : 88);
            fill_patterns();
            set_mask(pct, 1, MAXC-1);
            run(n, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0, dummy);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
